// File: rtl/wb_rr_interconnect.sv
// Shared-bus Wishbone interconnect: round-robin arbitration among N masters and
// address decode (adr[31:28]) to N slaves. Unmapped accesses and stalled slaves
// are terminated with an ERR_DATA acknowledge.
module wb_rr_interconnect #(
  parameter int                   N_MASTERS = 4,
  parameter int                   N_SLAVES  = 4,
  parameter int                   WB_DWIDTH = 32,
  parameter int                   WB_SWIDTH = 4,
  parameter int                   TIMEOUT   = 255,
  parameter logic [WB_DWIDTH-1:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                            i_clk,
  input  logic                            i_arst,
  input  logic [N_MASTERS*32-1:0]         i_m_wb_adr,
  input  logic [N_MASTERS*WB_SWIDTH-1:0]  i_m_wb_sel,
  input  logic [N_MASTERS-1:0]            i_m_wb_we,
  input  logic [N_MASTERS-1:0]            i_m_wb_cyc,
  input  logic [N_MASTERS-1:0]            i_m_wb_stb,
  input  logic [N_MASTERS*WB_DWIDTH-1:0]  i_m_wb_dat,
  output logic [N_MASTERS*WB_DWIDTH-1:0]  o_m_wb_dat,
  output logic [N_MASTERS-1:0]            o_m_wb_ack,
  output logic [N_SLAVES*32-1:0]          o_s_wb_adr,
  output logic [N_SLAVES*WB_SWIDTH-1:0]   o_s_wb_sel,
  output logic [N_SLAVES*WB_DWIDTH-1:0]   o_s_wb_dat,
  output logic [N_SLAVES-1:0]             o_s_wb_we,
  output logic [N_SLAVES-1:0]             o_s_wb_cyc,
  output logic [N_SLAVES-1:0]             o_s_wb_stb,
  input  logic [N_SLAVES*WB_DWIDTH-1:0]   i_s_wb_dat,
  input  logic [N_SLAVES-1:0]             i_s_wb_ack,
  output logic                            o_timeout,
  output logic [N_MASTERS-1:0]            o_grant,
  output logic [1:0]                      dbg_state
);

  // Handshake: a slave transfer completes in any cycle where the owner has
  // cyc&stb high and the decoded slave returns ack; ack/dat pass through
  // combinationally, so the owner sees the slave's ack in the same cycle.

  localparam int MW = $clog2(N_MASTERS);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [MW-1:0]          owner_q, owner_d;
  logic [MW-1:0]          winner, idx;
  logic                   found;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   to_q, to_d;

  logic [31:0]            own_adr;
  logic [WB_SWIDTH-1:0]   own_sel;
  logic [WB_DWIDTH-1:0]   own_dat;
  logic                   own_we, own_cyc, own_stb;
  logic [3:0]             slv;
  logic                   mapped;
  logic [WB_DWIDTH-1:0]   slv_dat;
  logic                   slv_ack;

  // Owner bus mux; owner_q also serves as the last owner for rotation.
  always_comb begin
    own_adr = '0;
    own_sel = '0;
    own_dat = '0;
    own_we  = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    for (int m = 0; m < N_MASTERS; m++) begin
      if (owner_q == MW'(m)) begin
        own_adr = i_m_wb_adr[m*32 +: 32];
        own_sel = i_m_wb_sel[m*WB_SWIDTH +: WB_SWIDTH];
        own_dat = i_m_wb_dat[m*WB_DWIDTH +: WB_DWIDTH];
        own_we  = i_m_wb_we[m];
        own_cyc = i_m_wb_cyc[m];
        own_stb = i_m_wb_stb[m];
      end
    end
  end

  assign slv    = own_adr[31:28];
  assign mapped = ({28'd0, slv} < 32'(N_SLAVES));

  always_comb begin
    slv_dat = '0;
    slv_ack = 1'b0;
    for (int s = 0; s < N_SLAVES; s++) begin
      if (slv == 4'(s)) begin
        slv_dat = i_s_wb_dat[s*WB_DWIDTH +: WB_DWIDTH];
        slv_ack = i_s_wb_ack[s];
      end
    end
  end

  // Round-robin search starting one past the previous owner.
  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = MW'((int'(owner_q) + i) % N_MASTERS);
      if (!found && i_m_wb_cyc[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = '0;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWN;
          owner_d = winner;
        end
      end
      OWN: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (own_stb && !mapped) begin
          state_d = ERR;
        end else if (own_stb && !slv_ack) begin
          // Last permitted wait cycle: slave stb was visible TIMEOUT cycles.
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = ERR;
            to_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ERR:     state_d = OWN;
      default: state_d = IDLE;
    endcase
    for (int m = 0; m < N_MASTERS; m++) begin
      grant_d[m] = (state_d != IDLE) && (owner_d == MW'(m));
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= IDLE;
      owner_q <= MW'(N_MASTERS - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // Routing is purely combinational from the registered state.
  always_comb begin
    o_s_wb_adr = '0;
    o_s_wb_sel = '0;
    o_s_wb_dat = '0;
    o_s_wb_we  = '0;
    o_s_wb_cyc = '0;
    o_s_wb_stb = '0;
    o_m_wb_dat = '0;
    o_m_wb_ack = '0;
    if (state_q == OWN && mapped) begin
      for (int s = 0; s < N_SLAVES; s++) begin
        if (slv == 4'(s)) begin
          o_s_wb_adr[s*32 +: 32]               = own_adr;
          o_s_wb_sel[s*WB_SWIDTH +: WB_SWIDTH] = own_sel;
          o_s_wb_dat[s*WB_DWIDTH +: WB_DWIDTH] = own_dat;
          o_s_wb_we[s]                         = own_we;
          o_s_wb_cyc[s]                        = own_cyc;
          o_s_wb_stb[s]                        = own_cyc & own_stb;
        end
      end
    end
    for (int m = 0; m < N_MASTERS; m++) begin
      if (owner_q == MW'(m)) begin
        if (state_q == OWN && mapped) begin
          o_m_wb_dat[m*WB_DWIDTH +: WB_DWIDTH] = slv_dat;
          o_m_wb_ack[m]                        = slv_ack & own_cyc & own_stb;
        end else if (state_q == ERR) begin
          o_m_wb_dat[m*WB_DWIDTH +: WB_DWIDTH] = ERR_DATA;
          o_m_wb_ack[m]                        = 1'b1;
        end
      end
    end
  end

  assign o_timeout = to_q;
  assign o_grant   = grant_q;
  assign dbg_state = state_q;

endmodule
